// File: rtl/seg_scan_mux_if.sv
// Bundle between the display-formatting logic (master) and the 7-segment scanner (slave).
// The master supplies the scan timing and the digit patterns. The slave returns the segment bus, the digit select and the frame tick.
interface seg_scan_mux_if #(
    parameter int NDIG = 4,
    parameter int BW   = 8,
    parameter int FBW  = 6
);
    logic [BW-1:0]     timeout;
    logic [BW-1:0]     guard;
    logic [FBW-1:0]    blink_frames;
    logic [8*NDIG-1:0] digits;
    logic [NDIG-1:0]   blank;
    logic [NDIG-1:0]   blink_en;
    logic [7:0]        digit;
    logic [NDIG-1:0]   digit_sel;
    logic              frame_tick;

    modport master (
        output timeout, guard, blink_frames, digits, blank, blink_en,
        input  digit, digit_sel, frame_tick
    );

    modport slave (
        input  timeout, guard, blink_frames, digits, blank, blink_en,
        output digit, digit_sel, frame_tick
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scan driver. It shows NDIG digits on one shared segment bus.
// It adds a guard band against ghosting, per-digit blank and blink, and a frame tick.
module seg_scan_mux #(
    parameter int NDIG           = 4,
    parameter int BW             = 8,
    parameter int FBW            = 6,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    seg_scan_mux_if.slave       bus
);
    localparam int         IW      = $clog2(NDIG);
    localparam logic [7:0] ALL_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [BW-1:0]   r_cnt;
    logic [IW-1:0]   r_idx;
    logic [FBW-1:0]  r_fcnt;
    logic            r_phase;
    logic [7:0]      r_digit;
    logic [NDIG-1:0] r_digit_sel;
    logic            r_frame_tick;

    logic [BW-1:0]   w_cnt_next;
    logic [IW-1:0]   w_idx_next;
    logic [FBW-1:0]  w_fcnt_next;
    logic            w_phase_next;
    logic [7:0]      w_digit_next;
    logic [NDIG-1:0] w_digit_sel_next;

    logic            w_slot_end;
    logic            w_frame_wrap;
    logic            w_win;
    logic            w_sup;
    logic [BW:0]     w_cnt_ext;
    logic [BW:0]     w_guard_ext;
    logic [BW:0]     w_timeout_ext;
    logic [BW:0]     w_tail;
    logic [FBW:0]    w_fcnt_inc;
    logic [7:0]      w_pat [NDIG];
    logic [NDIG-1:0] w_onehot;
    logic [NDIG-1:0] w_sup_vec;
    logic [7:0]      w_pat_sel;

    // Unpack the digit patterns. Decode the scan index once, as a one-hot vector.
    // The mux, the suppression and the select output all reuse that one decode.
    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            assign w_pat[gi]     = bus.digits[8*gi +: 8];
            assign w_onehot[gi]  = (r_idx == IW'(gi));
            assign w_sup_vec[gi] = bus.blank[gi] | (bus.blink_en[gi] & r_phase);
        end
    endgenerate

    always_comb begin
        w_pat_sel = 8'h00;
        for (int i = 0; i < NDIG; i++) begin
            if (w_onehot[i]) begin
                w_pat_sel = w_pat_sel | w_pat[i];
            end
        end
    end

    assign w_sup = |(w_onehot & w_sup_vec);

    // Compute the window with one extra bit. cnt+GUARD then cannot wrap past TIMEOUT.
    assign w_cnt_ext     = {1'b0, r_cnt};
    assign w_guard_ext   = {1'b0, bus.guard};
    assign w_timeout_ext = {1'b0, bus.timeout};
    assign w_tail        = w_cnt_ext + w_guard_ext;
    assign w_win         = (w_cnt_ext >= w_guard_ext) && (w_tail <= w_timeout_ext);

    // Use >= rather than == so that a TIMEOUT lowered below cnt ends the slot at once.
    assign w_slot_end   = (r_cnt >= bus.timeout);
    assign w_frame_wrap = w_slot_end && (r_idx == IW'(NDIG - 1));
    assign w_fcnt_inc   = {1'b0, r_fcnt} + {{FBW{1'b0}}, 1'b1};

    always_comb begin
        w_cnt_next = w_slot_end ? '0 : r_cnt + 1'b1;
        w_idx_next = r_idx;
        if (w_slot_end) begin
            w_idx_next = (r_idx == IW'(NDIG - 1)) ? '0 : r_idx + 1'b1;
        end
    end

    always_comb begin
        w_fcnt_next  = r_fcnt;
        w_phase_next = r_phase;
        if (w_frame_wrap) begin
            if (bus.blink_frames == '0) begin
                w_fcnt_next  = '0;
                w_phase_next = 1'b0;
            end else if (w_fcnt_inc >= {1'b0, bus.blink_frames}) begin
                w_fcnt_next  = '0;
                w_phase_next = ~r_phase;
            end else begin
                w_fcnt_next  = w_fcnt_inc[FBW-1:0];
            end
        end
    end

    always_comb begin
        w_digit_next     = w_sup ? ALL_OFF : w_pat_sel;
        w_digit_sel_next = (w_win && !w_sup) ? w_onehot : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_fcnt       <= '0;
            r_phase      <= 1'b0;
            r_digit      <= ALL_OFF;
            r_digit_sel  <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_next;
            r_idx        <= w_idx_next;
            r_fcnt       <= w_fcnt_next;
            r_phase      <= w_phase_next;
            r_digit      <= w_digit_next;
            r_digit_sel  <= w_digit_sel_next;
            r_frame_tick <= w_frame_wrap;
        end
    end

    assign bus.digit      = r_digit;
    assign bus.digit_sel  = r_digit_sel;
    assign bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomised scoreboard bench for seg_scan_mux. The reference model derives the expected outputs from the slot position and from the number of slots elapsed.
module tb_seg_scan_mux;
    localparam int         NDIG = 4;
    localparam int         BW   = 8;
    localparam int         FBW  = 6;
    localparam logic [7:0] OFF  = 8'hFF;

    typedef struct {
        logic [7:0]      d;
        logic [NDIG-1:0] s;
        logic            t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_mux_if #(.NDIG(NDIG), .BW(BW), .FBW(FBW)) bus();

    seg_scan_mux #(.NDIG(NDIG), .BW(BW), .FBW(FBW), .SEG_ACTIVE_LOW(1'b1)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   pos = 0;
    int   slots = 0;
    int   tick_exp = 0;
    int   last_tick = -1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, req);
        end
    endtask

    // Reference model. Phase is the number of whole frames elapsed divided by BLINK_FRAMES, taken mod 2.
    task automatic cycle();
        exp_t            e;
        int              idx, frames, ph;
        bit              sup, win;
        logic [NDIG-1:0] one;
        one = 1;
        if (rst) begin
            e.d = OFF; e.s = '0; e.t = 1'b0;
            pos = 0; slots = 0;
        end else begin
            idx    = slots % NDIG;
            frames = slots / NDIG;
            ph     = (bus.blink_frames == 0) ? 0 : (frames / int'(bus.blink_frames)) % 2;
            sup    = bus.blank[idx] || (bus.blink_en[idx] && ph == 1);
            win    = (pos >= int'(bus.guard)) && (pos + int'(bus.guard) <= int'(bus.timeout));
            e.d    = sup ? OFF : bus.digits[8*idx +: 8];
            e.s    = (win && !sup) ? (one << idx) : '0;
            e.t    = (pos >= int'(bus.timeout)) && (idx == NDIG - 1);
            if (pos >= int'(bus.timeout)) begin
                pos = 0;
                slots++;
            end else begin
                pos++;
            end
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic setup(input int t, input int g, input int bf, input int blk,
                         input int bln, input int period);
        tick_exp         = 0;
        rst              = 1'b1;
        bus.timeout      = BW'(t);
        bus.guard        = BW'(g);
        bus.blink_frames = FBW'(bf);
        bus.blank        = NDIG'(blk);
        bus.blink_en     = NDIG'(bln);
        cycle();
        cycle();
        rst       = 1'b0;
        last_tick = -1;
        tick_exp  = period;
    endtask

    task automatic run(input int n, input bit rnd);
        repeat (n) begin
            if (rnd) begin
                bus.digits   = {$urandom, $urandom};
                bus.blank    = NDIG'($urandom_range(0, 3) == 0 ? $urandom : 0);
                bus.blink_en = NDIG'($urandom);
            end
            cycle();
        end
    endtask

    // The monitor compares each registered output against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("digit", int'(bus.digit), int'(e.d));
                chk("digit_sel", int'(bus.digit_sel), int'(e.s));
                chk("frame_tick", int'(bus.frame_tick), int'(e.t));
                chk("onehot", ($countones(bus.digit_sel) <= 1) ? 1 : 0, 1);
                if (bus.frame_tick) begin
                    if (tick_exp > 0 && last_tick >= 0)
                        chk("tick_period", cyc - last_tick, tick_exp);
                    last_tick = cyc;
                end
            end
        end
    end

    initial begin
        bus.digits = {8'h66, 8'h4F, 8'h5B, 8'h06};

        // Basic scan with a one-cycle guard band.
        setup(9, 1, 0, 0, 0, 40);
        run(200, 1'b0);
        $display("phase basic done cycle=%0d", cyc);

        // The guard band covers the whole slot, so the select never asserts.
        setup(3, 2, 0, 0, 0, 16);
        run(100, 1'b0);
        $display("phase guard-wide done cycle=%0d", cyc);

        // Digit 1 blinks with two frames on and two frames off.
        setup(3, 0, 2, 0, 2, 16);
        run(200, 1'b0);
        $display("phase blink done cycle=%0d", cyc);

        // Digit 3 is blanked.
        setup(3, 1, 0, 8, 0, 16);
        run(100, 1'b0);
        $display("phase blank done cycle=%0d", cyc);

        // Lower TIMEOUT below the current count in the middle of a slot.
        setup(200, 3, 0, 0, 0, 0);
        for (int i = 0; i < 300 && pos != 100; i++) cycle();
        chk("reach_cnt100", pos, 100);
        bus.timeout = 8'd5;
        run(60, 1'b0);
        $display("phase timeout-lower done cycle=%0d", cyc);

        // Reset in the middle of the slot for digit 2.
        setup(9, 1, 0, 0, 0, 0);
        for (int i = 0; i < 200 && !((slots % NDIG) == 2 && pos == 4); i++) cycle();
        chk("reach_idx2", slots % NDIG, 2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        last_tick = -1;
        tick_exp = 40;
        run(100, 1'b0);
        $display("phase mid-reset done cycle=%0d", cyc);

        // With TIMEOUT and GUARD both zero, the digits rotate every cycle.
        setup(0, 0, 1, 0, 0, NDIG);
        run(40, 1'b1);
        $display("phase timeout0 done cycle=%0d", cyc);

        for (int k = 0; k < 20; k++) begin
            int t, g, bf;
            t  = $urandom_range(0, 12);
            g  = $urandom_range(0, 7);
            bf = $urandom_range(0, 3);
            setup(t, g, bf, 0, 0, NDIG * (t + 1));
            run(70, 1'b1);
            $display("random cfg %0d t=%0d g=%0d bf=%0d cycle=%0d", k, t, g, bf, cyc);
        end

        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Parametrised multiplexed 7-segment scan driver; successor to the fixed 4-digit scanner.
- Time-multiplexes NDIG digit patterns onto one shared segment bus with one-hot digit select.
- Adds a programmable anti-ghosting guard band, per-digit blank and blink, segment polarity, and a frame tick.
- Sits between the display-formatting logic and the board's segment/common pins.

Parameters:
- NDIG, 4, number of digits scanned (2..16)
- BW, 8, width of dwell counter and TIMEOUT/GUARD inputs
- FBW, 6, width of blink frame counter and BLINK_FRAMES input
- SEG_ACTIVE_LOW, 1, 1: segment bit 0 lights the segment; 0: segment bit 1 lights it

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- TIMEOUT  in  BW  dwell per digit slot, minus 1 (slot length = TIMEOUT+1 cycles)
- GUARD  in  BW  blanking cycles at each end of a slot
- BLINK_FRAMES  in  FBW  full scan frames per blink half-period; 0 disables blinking
- DIGITS  in  8*NDIG  segment patterns; digit i at [8i+7:8i], raw polarity per SEG_ACTIVE_LOW
- BLANK  in  NDIG  per-digit force-off
- BLINK_EN  in  NDIG  per-digit blink enable
- DIGIT  out  8  registered segment bus
- DIGIT_SEL  out  NDIG  registered one-hot digit select, active-high
- FRAME_TICK  out  1  one-cycle pulse at scan-frame wrap

Behaviour:
- Reset (RST high at a CLK edge): cnt=0, idx=0, fcnt=0, phase=0. DIGIT = all-off (8'hFF if SEG_ACTIVE_LOW, else 8'h00). DIGIT_SEL=0. FRAME_TICK=0. A mid-scan reset takes effect at that edge and restarts the scan from digit 0.
- Dwell counter cnt:
  - If cnt >= TIMEOUT, then cnt<=0 and the slot ends; otherwise cnt<=cnt+1.
  - The >= compare means a TIMEOUT lowered below cnt wraps at the next edge.
- Scan index idx: advances on slot end, wrapping NDIG-1 -> 0.
- Frame counter (on the slot end where idx wraps):
  - If BLINK_FRAMES==0: fcnt<=0 and phase<=0.
  - Else if fcnt+1 >= BLINK_FRAMES: fcnt<=0 and phase toggles.
  - Else: fcnt<=fcnt+1.
- FRAME_TICK: registered, high for one cycle on the cycle after the slot end where idx wraps.
- Window:
  - win = (cnt >= GUARD) && (cnt + GUARD <= TIMEOUT).
  - Evaluated in BW+1 bits, so there is no overflow.
  - When 2*GUARD > TIMEOUT, win is never true and DIGIT_SEL stays 0.
- Suppression: sup = BLANK[idx] | (BLINK_EN[idx] & phase).
- Output registers, updated every edge from current cnt/idx (one-cycle latency vs counter state):
  - DIGIT <= sup ? all-off : DIGITS[idx].
  - DIGIT_SEL <= (win & ~sup) ? (1<<idx) : 0.
- Invariants:
  - At most one DIGIT_SEL bit is high.
  - DIGIT_SEL is 0 for at least one cycle at every slot boundary when GUARD >= 1.
  - DIGIT changes only while DIGIT_SEL is 0 if GUARD >= 1 and DIGITS is stable.
- TIMEOUT=0:
  - Every cycle is a slot end.
  - With GUARD=0, win is always true, so digits rotate each cycle.
- DIGITS/BLANK/BLINK_EN: sampled every cycle, with no internal latching.

Test Plan:
- NDIG=4, TIMEOUT=9, GUARD=1, all digits distinct, no blank/blink, RST released -> each slot 10 cycles; DIGIT_SEL = 1,2,4,8 for 8 cycles each, 0 for 2 cycles between; FRAME_TICK every 40 cycles.
- TIMEOUT=3, GUARD=2 -> DIGIT_SEL never asserts; DIGIT still cycles through the patterns; FRAME_TICK every 16 cycles.
- BLINK_FRAMES=2, BLINK_EN=4'b0010, TIMEOUT=3, GUARD=0 -> digit 1 shows for 2 frames (32 cycles), then is off for 2 frames:
  - during the off frames DIGIT_SEL[1]=0 and DIGIT=8'hFF in its slot;
  - the other digits are unaffected.
- BLANK=4'b1000 with BLINK_FRAMES=0 -> digit 3 is never selected and DIGIT=8'hFF in its slot; phase stays 0.
- TIMEOUT lowered 200->5 while cnt=100 -> slot ends on the next edge and idx advances; subsequent slots are 6 cycles.
- RST asserted mid-slot at idx=2 -> next cycle DIGIT=8'hFF and DIGIT_SEL=0; after release, scan resumes at digit 0 with a full first slot.
